// File: rtl/bird_motion_ctrl.sv
// rtl/bird_motion_ctrl.sv - frame-synchronous bird sprite motion and game state controller
//
// Purpose: holds the game state machine. Once per video frame (during vertical
// blank) it integrates the bird's velocity and position and advances the wing
// animation. Commands and configuration arrive over a write-only Avalon slave.
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   chipselect, write     Avalon write qualifiers
//   address[2:0]          0 command (bit0 start, bit1 flap, bit2 pause-toggle),
//                         1 gravity[2:0], 2 flap magnitude[4:0], 3-7 ignored
//   writedata[7:0]        register data
//   hcount[10:0]          renderer horizontal counter
//   vcount[9:0]           renderer vertical counter
//   bird_y[9:0]           sprite top row
//   bird_frame[1:0]       wing animation frame 0..2
//   game_state[1:0]       0 IDLE, 1 PLAY, 2 PAUSE, 3 DEAD
//   game_over             one-cycle pulse on the cycle DEAD first shows
module bird_motion_ctrl #(
  parameter int Y_INIT   = 240,
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = 456,
  parameter int VMAX     = 10,
  parameter int ANIM_DIV = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic [2:0]  address,
  input  logic [7:0]  writedata,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  output logic [9:0]  bird_y,
  output logic [1:0]  bird_frame,
  output logic [1:0]  game_state,
  output logic        game_over
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_PAUSE = 2'd2,
    S_DEAD  = 2'd3
  } state_t;

  localparam logic signed [7:0]  VMAX_S = 8'(VMAX);
  localparam logic signed [11:0] YMAX_S = 12'(Y_MAX);
  localparam logic signed [11:0] YMIN_S = 12'(Y_MIN);
  localparam logic [7:0]         DIV_LAST = 8'(ANIM_DIV - 1);

  state_t            state, state_nx;
  logic              tick;
  logic              pend_start, pend_flap, pend_pause;
  logic [2:0]        gravity;
  logic [4:0]        flap_mag;
  logic signed [6:0] vel, vel_nx, vel_upd;
  logic signed [7:0] vel_sum;
  logic signed [11:0] ny;
  logic [9:0]        y, y_nx;
  logic [7:0]        div, div_nx, div_adv;
  logic [1:0]        frame, frame_nx, frame_adv;
  logic              over_nx;
  logic              cmd_wr;
  logic              unused_ok;

  assign cmd_wr    = chipselect && write && (address == 3'd0);
  assign unused_ok = ^writedata[7:5];

  // Registered frame tick: one cycle after the renderer reaches (480,0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tick <= 1'b0;
    else       tick <= (vcount == 10'd480) && (hcount == 11'd0);
  end

  // Sticky command flags; a write landing with tick survives for the next tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_start <= 1'b0;
      pend_flap  <= 1'b0;
      pend_pause <= 1'b0;
      gravity    <= 3'd1;
      flap_mag   <= 5'd8;
    end else begin
      pend_start <= (cmd_wr && writedata[0]) || (pend_start && !tick);
      pend_flap  <= (cmd_wr && writedata[1]) || (pend_flap  && !tick);
      pend_pause <= (cmd_wr && writedata[2]) || (pend_pause && !tick);
      if (chipselect && write && address == 3'd1) gravity  <= writedata[2:0];
      if (chipselect && write && address == 3'd2) flap_mag <= writedata[4:0];
    end
  end

  // Velocity and candidate row, done in signed arithmetic wide enough that a
  // flap near the ceiling shows up as negative instead of wrapping.
  always_comb begin
    vel_sum = {vel[6], vel} + $signed({5'b0, gravity});
    if (pend_flap)             vel_upd = 7'd0 - {2'b0, flap_mag};
    else if (vel_sum > VMAX_S) vel_upd = VMAX_S[6:0];
    else                       vel_upd = vel_sum[6:0];
    ny = $signed({2'b0, y}) + {{5{vel_upd[6]}}, vel_upd};
  end

  always_comb begin
    if (div == DIV_LAST) begin
      div_adv   = 8'd0;
      frame_adv = (frame == 2'd2) ? 2'd0 : frame + 2'd1;
    end else begin
      div_adv   = div + 8'd1;
      frame_adv = frame;
    end
  end

  always_comb begin
    state_nx = state;
    y_nx     = y;
    vel_nx   = vel;
    div_nx   = div;
    frame_nx = frame;
    over_nx  = 1'b0;
    if (tick) begin
      case (state)
        S_IDLE: begin
          y_nx     = 10'(Y_INIT);
          vel_nx   = 7'sd0;
          div_nx   = div_adv;
          frame_nx = frame_adv;
          if (pend_start) state_nx = S_PLAY;
        end
        S_PLAY: begin
          if (pend_pause) begin
            state_nx = S_PAUSE;
          end else if (ny >= YMAX_S) begin
            y_nx     = 10'(Y_MAX);
            vel_nx   = 7'sd0;
            state_nx = S_DEAD;
            over_nx  = 1'b1;
            div_nx   = 8'd0;
            frame_nx = 2'd0;
          end else begin
            if (ny < YMIN_S) begin
              y_nx   = 10'(Y_MIN);
              vel_nx = 7'sd0;
            end else begin
              y_nx   = ny[9:0];
              vel_nx = vel_upd;
            end
            div_nx   = div_adv;
            frame_nx = frame_adv;
          end
        end
        S_PAUSE: begin
          if (pend_start) begin
            state_nx = S_IDLE;
            y_nx     = 10'(Y_INIT);
            vel_nx   = 7'sd0;
            div_nx   = 8'd0;
            frame_nx = 2'd0;
          end else if (pend_pause) begin
            state_nx = S_PLAY;
          end
        end
        default: begin
          div_nx   = 8'd0;
          frame_nx = 2'd0;
          if (pend_start) begin
            state_nx = S_IDLE;
            y_nx     = 10'(Y_INIT);
            vel_nx   = 7'sd0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y         <= 10'(Y_INIT);
      vel       <= 7'sd0;
      div       <= 8'd0;
      frame     <= 2'd0;
      game_over <= 1'b0;
    end else begin
      y         <= y_nx;
      vel       <= vel_nx;
      div       <= div_nx;
      frame     <= frame_nx;
      game_over <= over_nx;
    end
  end

  assign bird_y     = y;
  assign bird_frame = (state == S_DEAD) ? 2'd0 : frame;
  assign game_state = state;

endmodule

// File: tb/tb_bird_motion_ctrl.sv
// tb/tb_bird_motion_ctrl.sv - directed self-checking bench for bird_motion_ctrl
module tb_bird_motion_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        chipselect = 1'b0;
  logic        write = 1'b0;
  logic [2:0]  address = 3'd0;
  logic [7:0]  writedata = 8'd0;
  logic [10:0] hcount = 11'd100;
  logic [9:0]  vcount = 10'd0;
  logic [9:0]  bird_y;
  logic [1:0]  bird_frame;
  logic [1:0]  game_state;
  logic        game_over;

  int total = 0;
  int bad = 0;

  bird_motion_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .chipselect (chipselect),
    .write      (write),
    .address    (address),
    .writedata  (writedata),
    .hcount     (hcount),
    .vcount     (vcount),
    .bird_y     (bird_y),
    .bird_frame (bird_frame),
    .game_state (game_state),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0; address = 3'd0; writedata = 8'd0;
  endtask

  // One video frame: counters hit (480,0), tick rises next cycle, outputs
  // update the cycle after. Optionally writes a command during the tick cycle.
  task automatic frame_tick(input logic wr_on_tick, input logic [7:0] cmd);
    @(negedge clk);
    vcount = 10'd480; hcount = 11'd0;
    @(negedge clk);
    vcount = 10'd0; hcount = 11'd100;
    if (wr_on_tick) begin
      chipselect = 1'b1; write = 1'b1; address = 3'd0; writedata = cmd;
    end
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0; writedata = 8'd0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame_tick(1'b0, 8'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_y", bird_y, 240);
    chk("rst_frame", bird_frame, 0);
    chk("rst_state", game_state, 0);
    chk("rst_over", game_over, 0);

    // start; near-miss counter values must not tick
    wr_reg(3'd0, 8'h01);
    @(negedge clk); vcount = 10'd480; hcount = 11'd1;
    @(negedge clk); vcount = 10'd479; hcount = 11'd0;
    @(negedge clk); vcount = 10'd0;   hcount = 11'd100;
    @(negedge clk);
    chk("no_tick_state", game_state, 0);
    frame_tick(1'b0, 8'd0);
    chk("start_state", game_state, 1);
    chk("start_y", bird_y, 240);
    frame_tick(1'b0, 8'd0);
    chk("fall1_y", bird_y, 241);

    // free fall to the ground
    frames(9);
    chk("fall10_y", bird_y, 295);
    frames(16);
    chk("fall26_y", bird_y, 455);
    chk("fall26_over", game_over, 0);
    frame_tick(1'b0, 8'd0);
    chk("fall27_y", bird_y, 456);
    chk("dead_state", game_state, 3);
    chk("over_pulse", game_over, 1);
    chk("dead_frame", bird_frame, 0);
    @(negedge clk);
    chk("over_single", game_over, 0);

    // restart to IDLE, animation in IDLE
    wr_reg(3'd0, 8'h01);
    frame_tick(1'b0, 8'd0);
    chk("idle_state", game_state, 0);
    chk("idle_y", bird_y, 240);
    chk("idle_frame0", bird_frame, 0);
    frames(5);
    chk("anim_5", bird_frame, 0);
    frames(1);
    chk("anim_6", bird_frame, 1);
    frames(6);
    chk("anim_12", bird_frame, 2);
    frames(6);
    chk("anim_18", bird_frame, 0);

    // flap sequence
    wr_reg(3'd0, 8'h01);
    frame_tick(1'b0, 8'd0);
    chk("play2_y", bird_y, 240);
    wr_reg(3'd0, 8'h02);
    frame_tick(1'b0, 8'd0);
    chk("flap_y1", bird_y, 232);
    frame_tick(1'b0, 8'd0);
    chk("flap_y2", bird_y, 225);
    frame_tick(1'b0, 8'd0);
    chk("flap_y3", bird_y, 219);
    wr_reg(3'd0, 8'h02);
    frame_tick(1'b0, 8'd0);
    chk("reflap_y", bird_y, 211);

    // pause freezes motion and animation (divider at 5, frame 0)
    wr_reg(3'd0, 8'h04);
    frame_tick(1'b0, 8'd0);
    chk("pause_state", game_state, 2);
    chk("pause_y0", bird_y, 211);
    frames(10);
    chk("pause_y10", bird_y, 211);
    frames(10);
    chk("pause_y20", bird_y, 211);
    chk("pause_frame20", bird_frame, 0);
    wr_reg(3'd0, 8'h04);
    frame_tick(1'b0, 8'd0);
    chk("resume_state", game_state, 1);
    chk("resume_y", bird_y, 211);
    frame_tick(1'b0, 8'd0);
    chk("resume_move_y", bird_y, 204);
    chk("resume_frame", bird_frame, 1);

    // flap written in the tick cycle applies one tick later
    frame_tick(1'b1, 8'h02);
    chk("late_flap_y", bird_y, 198);
    frame_tick(1'b0, 8'd0);
    chk("late_flap_next_y", bird_y, 190);

    // ceiling clamp with flap magnitude 31
    wr_reg(3'd2, 8'd31);
    for (int i = 0; i < 6; i++) begin
      wr_reg(3'd0, 8'h02);
      frame_tick(1'b0, 8'd0);
    end
    chk("ceil6_y", bird_y, 4);
    wr_reg(3'd0, 8'h02);
    frame_tick(1'b0, 8'd0);
    chk("ceil7_y", bird_y, 0);
    chk("ceil_state", game_state, 1);

    // gravity 3 from rest at the ceiling; ignored offset write
    wr_reg(3'd1, 8'd3);
    wr_reg(3'd5, 8'hff);
    frame_tick(1'b0, 8'd0);
    chk("grav3_y1", bird_y, 3);
    frame_tick(1'b0, 8'd0);
    chk("grav3_y2", bird_y, 9);

    // asynchronous reset mid-play
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("areset_y", bird_y, 240);
    chk("areset_state", game_state, 0);
    @(negedge clk);
    reset = 1'b0;
    wr_reg(3'd0, 8'h01);
    frame_tick(1'b0, 8'd0);
    frame_tick(1'b0, 8'd0);
    chk("post_rst_grav_y", bird_y, 241);
    wr_reg(3'd0, 8'h02);
    frame_tick(1'b0, 8'd0);
    chk("post_rst_flap_y", bird_y, 233);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bird_motion_ctrl.md
# bird_motion_ctrl

Frame-synchronous controller that sequences the Flappy Bird sprite: it owns the game state machine, integrates bird vertical velocity and position once per video frame, and advances the three-frame wing animation. It sits between the Avalon-MM software interface and the VGA renderer. It consumes the renderer's `hcount`/`vcount` counters and drives `bird_y` and `bird_frame` into the sprite address/compose logic. All updates land during vertical blanking, so the displayed sprite never tears.

## Interface
Parameters:
- `Y_INIT`, 240: bird row in IDLE and after restart.
- `Y_MIN`, 0: ceiling row.
- `Y_MAX`, 456: ground row (480 minus 24-pixel sprite height).
- `VMAX`, 10: terminal downward velocity, in px/frame.
- `ANIM_DIV`, 6: video frames per animation step.

Ports:
- `clk`  in  1: 50 MHz system clock.
- `reset`  in  1: asynchronous, active-high.
- `chipselect`  in  1: Avalon select.
- `write`  in  1: Avalon write strobe.
- `address`  in  3: register offset.
- `writedata`  in  8: register data.
- `hcount`  in  11: renderer horizontal counter (0–1599).
- `vcount`  in  10: renderer vertical counter (0–524).
- `bird_y`  out  10: sprite top row.
- `bird_frame`  out  2: animation frame, 0–2.
- `game_state`  out  2: 0 IDLE, 1 PLAY, 2 PAUSE, 3 DEAD.
- `game_over`  out  1: one-cycle pulse on entry to DEAD.

## Operation
Register map (writes only, active when `chipselect & write`):
- Offset 0, command. Each bit, when written as 1, sets a sticky pending flag:
  - bit0: start
  - bit1: flap
  - bit2: pause-toggle
- Offset 1, bits [2:0]: gravity, in px/frame² (reset 1).
- Offset 2, bits [4:0]: flap magnitude, in px/frame (reset 8).
- Offsets 3–7 are ignored.

Frame tick:
- `tick` is registered: asserted the cycle after `vcount==480 && hcount==0`.
- Exactly one tick per frame.
- All pending flags are consumed and cleared on `tick`.
- A write in the same cycle as `tick` sets its flag (set wins over clear) and is serviced at the next tick.

State machine, evaluated only on `tick`:
- IDLE:
  - Hold `bird_y = Y_INIT` and velocity 0; animation runs.
  - start → PLAY. Flap and pause are discarded.
- PLAY (flap, or gravity and position update):
  - If flap is pending: `vel = -flap_mag`.
  - Otherwise: `vel = min(vel + gravity, VMAX)`.
  - Then `ny = bird_y + vel`, computed signed 12-bit.
- PLAY (boundaries):
  - If `ny >= Y_MAX`: `bird_y = Y_MAX`, vel = 0, go to DEAD, pulse `game_over`.
  - Else if `ny < Y_MIN`: `bird_y = Y_MIN`, vel = 0.
  - Else `bird_y = ny`.
- PLAY (other commands):
  - pause-toggle → PAUSE, with no position update that tick.
  - start is ignored.
- PAUSE:
  - Position, velocity and animation are frozen.
  - pause-toggle → PLAY; the update resumes on the following tick.
  - start → IDLE.
- DEAD:
  - Frozen; `bird_frame` is forced to 0.
  - start → IDLE. Flap and pause are discarded.
- Priority when several flags are pending at the same tick: start > pause > flap.
- Velocity is a signed 7-bit register, range −31..+VMAX.

Animation:
- A divider counts ticks from 0 to ANIM_DIV−1.
- On wrap, `bird_frame` advances 0→1→2→0.
- The divider runs in IDLE and PLAY, holds in PAUSE, and is cleared in DEAD.
- Entering IDLE clears both the divider and `bird_frame`.

## Timing
- Reset values:
  - `bird_y = Y_INIT`, `bird_frame = 0`, `game_state = IDLE`, `game_over = 0`.
  - Velocity 0, pending flags 0, gravity 1, flap magnitude 8, divider 0.
- Latency:
  - `vcount/hcount` match → `tick`: 1 cycle.
  - `tick` → updated `bird_y`, `bird_frame`, `game_state`: 1 cycle.
  - Net: 2 cycles after (480,0), i.e. well inside vertical blank.
- `game_over` is high for exactly the one cycle in which `game_state` first shows DEAD.
- Outputs are stable for the rest of the frame.
- Reset mid-operation returns all state to reset values immediately (asynchronous), regardless of pending writes.
- Config registers take effect at the next tick after the write.

## Test plan
1. Reset, then write start → after the first tick `game_state = 1`, `bird_y = 240`, vel 0. After the next tick, `bird_y = 241`.
2. Free fall with gravity 1 from `bird_y = 240`, vel 0, in PLAY:
   - After 10 update ticks: `bird_y = 295`.
   - After 26 update ticks: `bird_y = 455`.
   - On update tick 27: `bird_y = 456`, `game_state = 3`, single-cycle `game_over`.
3. Flap from `bird_y = 240`, vel 0 → `bird_y = 232`, then 225 and 219 on the next ticks. A second flap restores vel to −8.
4. Flap repeatedly near the ceiling (e.g. with flap magnitude 31) → `bird_y` clamps at 0 with vel 0. No DEAD, and `bird_y` never wraps to a large value.
5. Write pause in PLAY → `bird_y` and `bird_frame` are constant over 20 ticks. Pause again → motion resumes from the same velocity.
6. Write flap in the exact cycle of `tick` → it is not applied that tick but is applied on the next. Start during DEAD → IDLE with `bird_y = 240`, `bird_frame = 0`. In IDLE, `bird_frame` steps every 6 ticks: 0,1,2,0.
